// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared constants for the EX-stage integer divider.
//   - DIV_OP_* : 2-bit operation encodings. Bit 0 selects unsigned and bit 1
//                selects remainder.
//   - div_state_e : divider FSM state encoding.
//   - op_is_unsigned / op_is_rem : decode helpers for the op field.
package ex_div_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

    function automatic logic op_is_unsigned(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/ex_div_core_step.sv
// div_core_step: combinational datapath for one restoring-division iteration,
// plus the final sign correction.
//   rem_i / quo_i : partial remainder and the dividend/quotient shift register.
//   dvs_i         : divisor magnitude.
//   rem_o / quo_o : state after one iteration.
//   sel_rem_i     : selects the remainder (1) or the quotient (0) for res_o.
//   neg_i         : two's-complement negates the selected value.
//   res_o         : the selected value after sign correction.
module div_core_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    input  logic             sel_rem_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] res_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sel;

    // The quotient register also holds the dividend. Each iteration shifts
    // one dividend bit out of the MSB and one quotient bit into the LSB.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_i};

    always_comb begin
        rem_o = shifted[WIDTH-1:0];
        quo_o = {quo_i[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

    assign sel   = sel_rem_i ? rem_i : quo_i;
    assign res_o = neg_i ? (~sel + WIDTH'(1)) : sel;

endmodule

// File: rtl/ex_div.sv
// ex_div: iterative RV32M DIV/DIVU/REM/REMU unit in the EX stage. It uses
// radix-2 restoring division and produces one quotient bit per cycle.
//   clk, rst      : clock and asynchronous active-low reset.
//   start_i       : a divide op with valid operands is present this cycle.
//   op_i          : operation (see DIV_OP_* in ex_div_pkg).
//   dividend_i    : rs1 value.
//   divisor_i     : rs2 value.
//   rd_addr_i     : destination register.
//   flush_i       : kills any operation in progress and wins over start_i.
//   hold_o        : stall request to the PC, IF/ID and ID/EX registers.
//   busy_o        : the FSM is not idle.
//   valid_o       : one-cycle result strobe.
//   reg_wen_o     : equals valid_o.
//   result_o      : the result, zero while valid_o is low.
//   rd_addr_o     : the destination register, zero while valid_o is low.
//   state_o       : current FSM state, for debug visibility.
// Handshake: start_i is sampled only in IDLE. Exactly one valid_o pulse
// follows each accepted start unless a flush or reset intervenes.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             flush_i,
    output logic             hold_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_addr_o,
    output logic             reg_wen_o,
    output logic [1:0]       state_o
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_rem_q, is_rem_d;
    logic [4:0]       rd_q, rd_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             is_signed;
    logic             div_zero;
    logic             sgn_ovf;
    logic             special;
    logic [WIDTH-1:0] special_val;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] final_res;
    logic             accept;

    assign is_signed = !op_is_unsigned(op_i);
    assign div_zero  = (divisor_i == '0);
    assign sgn_ovf   = is_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
    assign special   = div_zero || sgn_ovf;
    assign accept    = (state_q == DIV_ST_IDLE) && start_i && !flush_i;

    always_comb begin
        special_val = '0;
        if (div_zero) begin
            special_val = op_is_rem(op_i) ? dividend_i : '1;
        end else if (sgn_ovf) begin
            special_val = op_is_rem(op_i) ? '0 : MIN_NEG;
        end
    end

    assign dvd_mag = (is_signed && dividend_i[WIDTH-1]) ? (~dividend_i + WIDTH'(1)) : dividend_i;
    assign dvs_mag = (is_signed && divisor_i[WIDTH-1])  ? (~divisor_i + WIDTH'(1))  : divisor_i;

    div_core_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .dvs_i     (dvs_q),
        .sel_rem_i (is_rem_q),
        .neg_i     (is_rem_q ? neg_rem_q : neg_quo_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo),
        .res_o     (final_res)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        rd_d      = rd_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        unique case (state_q)
            DIV_ST_IDLE: begin
                if (accept) begin
                    is_rem_d = op_is_rem(op_i);
                    rd_d     = rd_addr_i;
                    cnt_d    = '0;
                    if (special) begin
                        // The special result goes into both result registers
                        // with no sign correction, so DONE needs no extra
                        // path for it.
                        quo_d     = special_val;
                        rem_d     = special_val;
                        dvs_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = DIV_ST_DONE;
                    end else begin
                        quo_d     = dvd_mag;
                        rem_d     = '0;
                        dvs_d     = dvs_mag;
                        neg_quo_d = is_signed && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        neg_rem_d = is_signed && dividend_i[WIDTH-1];
                        state_d   = DIV_ST_CALC;
                    end
                end
            end
            DIV_ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_ST_DONE;
                end
            end
            DIV_ST_DONE: begin
                state_d = DIV_ST_IDLE;
            end
            default: begin
                state_d = DIV_ST_IDLE;
            end
        endcase
        if (flush_i) begin
            state_d = DIV_ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_ST_IDLE;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            rd_q      <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            rd_q      <= rd_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // The stall releases in DONE, so the result writes back in the same cycle
    // the front of the pipeline moves again.
    assign hold_o    = (accept && !special) || (state_q == DIV_ST_CALC);
    assign busy_o    = (state_q != DIV_ST_IDLE);
    assign valid_o   = (state_q == DIV_ST_DONE) && !flush_i;
    assign reg_wen_o = valid_o;
    assign result_o  = valid_o ? final_res : '0;
    assign rd_addr_o = valid_o ? rd_q : '0;
    assign state_o   = state_q;

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;
  import ex_div_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        hold_o, busy_o, valid_o, reg_wen_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  ex_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .hold_o     (hold_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .reg_wen_o  (reg_wen_o),
    .state_o    (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];   // {rd, result}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pops the expected queue whenever a result strobe appears
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (valid_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", {rd_addr_o, result_o}, 37'h0);
          end else begin
            e = exp_q.pop_front();
            check("result", {rd_addr_o, result_o}, e);
            check("reg_wen", reg_wen_o, 1);
          end
        end else begin
          check("idle_outputs_zero", {result_o, rd_addr_o, reg_wen_o}, 0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // flush_at / poke_at / reset_at: iteration index (0 = unused)
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input bit special,
                        input int flush_at, input int poke_at, input int reset_at);
    int hold_cnt;
    int lat;
    if (flush_at == 0 && reset_at == 0) exp_q.push_back({rd, exp_res});
    @(negedge clk);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    #2;
    check("hold_at_start", hold_o, {63'b0, !special});
    hold_cnt = hold_o ? 1 : 0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    op_i = 2'($urandom_range(0, 3));
    dividend_i = $urandom;
    divisor_i = $urandom;
    rd_addr_i = 5'($urandom_range(0, 31));
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == poke_at) begin
        start_i = 1'b1; op_i = DIV_OP_DIV; dividend_i = 32'd9; divisor_i = 32'd3; rd_addr_i = rd ^ 5'h1f;
      end else begin
        start_i = 1'b0;
      end
      if (k == flush_at) flush_i = 1'b1;
      #2;
      if (k == reset_at) begin
        rst = 1'b0;
        #1;
        check("reset_async_outputs",
              {hold_o, busy_o, valid_o, result_o, rd_addr_o, reg_wen_o, state_o}, 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (hold_o) hold_cnt++;
      if (valid_o) begin
        lat = k;
        break;
      end
      if (k == flush_at) begin
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        #2;
        check("flush_to_idle", {hold_o, busy_o, valid_o, state_o}, 0);
        return;
      end
    end
    check("latency", lat, special ? 1 : 33);
    check("hold_cycles", hold_cnt, special ? 0 : 33);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("reset_state",
          {hold_o, busy_o, valid_o, result_o, rd_addr_o, reg_wen_o, state_o}, 0);
    rst = 1'b1;

    //     op           dividend      divisor       rd     expected      spec flush poke reset
    run_op(DIV_OP_DIVU, 32'd100,      32'd7,        5'd3,  32'd14,       1'b0, 0, 0, 0);
    run_op(DIV_OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 1'b0, 0, 0, 0);
    run_op(DIV_OP_REM,  32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFF, 1'b0, 0, 0, 0);
    run_op(DIV_OP_REMU, 32'hFFFFFFF9, 32'd2,        5'd6,  32'd1,        1'b0, 0, 0, 0);
    run_op(DIV_OP_DIV,  32'd20,       32'hFFFFFFFD, 5'd7,  32'hFFFFFFFA, 1'b0, 0, 0, 0);
    run_op(DIV_OP_REM,  32'd20,       32'hFFFFFFFD, 5'd8,  32'd2,        1'b0, 0, 0, 0);
    run_op(DIV_OP_DIVU, 32'hFFFFFFFF, 32'd1,        5'd9,  32'hFFFFFFFF, 1'b0, 0, 0, 0);
    // divide by zero
    run_op(DIV_OP_DIV,  32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1'b1, 0, 0, 0);
    run_op(DIV_OP_REM,  32'd5,        32'd0,        5'd11, 32'd5,        1'b1, 0, 0, 0);
    run_op(DIV_OP_REMU, 32'd7,        32'd0,        5'd12, 32'd7,        1'b1, 0, 0, 0);
    // signed overflow
    run_op(DIV_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 1'b1, 0, 0, 0);
    run_op(DIV_OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0,        1'b1, 0, 0, 0);
    // same operands unsigned: ordinary long division
    run_op(DIV_OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1'b0, 0, 0, 0);
    // flush at iteration 10, then a fresh op
    run_op(DIV_OP_DIVU, 32'd1000,     32'd3,        5'd16, 32'd333,      1'b0, 10, 0, 0);
    run_op(DIV_OP_DIVU, 32'd9,        32'd3,        5'd17, 32'd3,        1'b0, 0, 0, 0);
    // start pulsed during CALC must be ignored
    run_op(DIV_OP_DIVU, 32'd100,      32'd7,        5'd18, 32'd14,       1'b0, 0, 5, 0);
    // asynchronous reset mid-CALC
    run_op(DIV_OP_DIVU, 32'd12345,    32'd11,       5'd19, 32'd1122,     1'b0, 0, 0, 12);
    run_op(DIV_OP_REMU, 32'd12345,    32'd11,       5'd20, 32'd3,        1'b0, 0, 0, 0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
